pc_redirect_ctrl: RTL and testbench

Sequencing controller for the fetch-stage program counter. Arbitrates all control-flow redirect sources (trap entry, mret, EX-stage branch/jump, fence.i) and the fetch stall sources, and drives the PC register's `j_signal` / `jump` / `stall` inputs plus the IF/ID and ID/EX flush lines. It holds a redirect that arrives while instruction memory is busy and sequences the fence.i invalidate handshake. Sits between EX/CSR logic and the PC register in the core.

---
 rtl/pc_ctrl_pkg.sv | 26 ++
 rtl/redirect_arbiter.sv | 47 ++++
 rtl/pc_redirect_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch PC redirect controller.
//   state_t      : controller state (RUN / HOLD / INVAL)
//   CAUSE_*      : redirect cause encoding driven on redirect_cause
//   ALIGN_MASK   : clears the two low bits of a redirect target
//   align_pc()   : applies ALIGN_MASK to a target address
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_INVAL = 2'd2
  } state_t;

  localparam logic [2:0] CAUSE_NONE   = 3'd0;
  localparam logic [2:0] CAUSE_TRAP   = 3'd1;
  localparam logic [2:0] CAUSE_MRET   = 3'd2;
  localparam logic [2:0] CAUSE_BRANCH = 3'd3;
  localparam logic [2:0] CAUSE_FENCEI = 3'd4;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/redirect_arbiter.sv
// Combinational priority encoder over the redirect sources.
// Priority: trap > mret > branch > fence.i. Only the winner is reported;
// lower-priority requests in the same cycle are dropped.
// Ports:
//   trap_req/trap_vector, mret_req/mepc, br_taken/br_target,
//   fencei_req/fencei_pc : request/target pairs
//   win_vld              : some request is active
//   win_tgt              : winner's target, word aligned
//   win_cause            : winner's cause code (CAUSE_NONE when idle)
module redirect_arbiter
  import pc_ctrl_pkg::*;
(
  input  logic        trap_req,
  input  logic [31:0] trap_vector,
  input  logic        mret_req,
  input  logic [31:0] mepc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        fencei_req,
  input  logic [31:0] fencei_pc,
  output logic        win_vld,
  output logic [31:0] win_tgt,
  output logic [2:0]  win_cause
);

  always_comb begin
    win_vld   = 1'b1;
    win_tgt   = '0;
    win_cause = CAUSE_NONE;
    if (trap_req) begin
      win_tgt   = align_pc(trap_vector);
      win_cause = CAUSE_TRAP;
    end else if (mret_req) begin
      win_tgt   = align_pc(mepc);
      win_cause = CAUSE_MRET;
    end else if (br_taken) begin
      win_tgt   = align_pc(br_target);
      win_cause = CAUSE_BRANCH;
    end else if (fencei_req) begin
      win_tgt   = align_pc(fencei_pc);
      win_cause = CAUSE_FENCEI;
    end else begin
      win_vld   = 1'b0;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC redirect controller.
// Arbitrates trap/mret/branch/fence.i redirects and fetch stall sources,
// drives the PC register's j_signal/jump/stall and the IF/ID, ID/EX flushes.
// A redirect arriving while imem is busy is parked (HOLD); fence.i runs an
// icache invalidate handshake with a timeout (INVAL).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   trap_req/trap_vector     : trap entry (highest priority)
//   mret_req/mepc            : mret
//   br_taken/br_target       : EX-stage taken branch/jump
//   fencei_req/fencei_pc     : fence.i retiring, PC+4 target
//   icache_inv_done          : invalidate completion pulse
//   load_use_hazard          : hazard-unit stall
//   imem_ready               : imem can accept a new fetch address
//   pc_j_signal/pc_jump      : PC load strobe and target
//   pc_stall                 : PC hold
//   flush_if_id/flush_id_ex  : pipeline kills
//   icache_inv_req           : one-cycle invalidate request
//   redirect_cause           : cause of current/pending redirect
//   busy                     : controller not in RUN
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int INV_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [31:0] trap_vector,
  input  logic        mret_req,
  input  logic [31:0] mepc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        fencei_req,
  input  logic [31:0] fencei_pc,
  input  logic        icache_inv_done,
  input  logic        load_use_hazard,
  input  logic        imem_ready,
  output logic        pc_j_signal,
  output logic [31:0] pc_jump,
  output logic        pc_stall,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        icache_inv_req,
  output logic [2:0]  redirect_cause,
  output logic        busy
);

  localparam int CNT_W = (INV_TIMEOUT > 1) ? $clog2(INV_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INV_TIMEOUT - 1);

  state_t            state, state_nx;
  logic [31:0]       pend_tgt, pend_tgt_nx;
  logic [2:0]        pend_cause, pend_cause_nx;
  logic [CNT_W-1:0]  inv_cnt, inv_cnt_nx;

  logic              win_vld;
  logic [31:0]       win_tgt;
  logic [2:0]        win_cause;
  logic              urgent;

  logic              jmp;
  logic [31:0]       jmp_tgt;
  logic              flush;
  logic              inv_req;
  logic              fence_start;
  logic [2:0]        cause;

  redirect_arbiter u_arb (
    .trap_req    (trap_req),
    .trap_vector (trap_vector),
    .mret_req    (mret_req),
    .mepc        (mepc),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .fencei_req  (fencei_req),
    .fencei_pc   (fencei_pc),
    .win_vld     (win_vld),
    .win_tgt     (win_tgt),
    .win_cause   (win_cause)
  );

  // Only trap and mret may preempt a parked redirect or an invalidate.
  assign urgent = win_vld && ((win_cause == CAUSE_TRAP) || (win_cause == CAUSE_MRET));

  always_comb begin
    state_nx      = state;
    pend_tgt_nx   = pend_tgt;
    pend_cause_nx = pend_cause;
    inv_cnt_nx    = inv_cnt;
    jmp           = 1'b0;
    jmp_tgt       = '0;
    flush         = 1'b0;
    inv_req       = 1'b0;
    fence_start   = 1'b0;
    cause         = CAUSE_NONE;

    case (state)
      ST_RUN: begin
        if (win_vld && (win_cause != CAUSE_FENCEI)) begin
          flush = 1'b1;
          if (imem_ready) begin
            jmp     = 1'b1;
            jmp_tgt = win_tgt;
            cause   = win_cause;
          end else begin
            pend_tgt_nx   = win_tgt;
            pend_cause_nx = win_cause;
            state_nx      = ST_HOLD;
          end
        end else if (win_vld) begin
          inv_req       = 1'b1;
          flush         = 1'b1;
          fence_start   = 1'b1;
          pend_tgt_nx   = win_tgt;
          pend_cause_nx = CAUSE_FENCEI;
          inv_cnt_nx    = '0;
          state_nx      = ST_INVAL;
        end
      end

      ST_HOLD: begin
        cause = pend_cause;
        if (urgent) begin
          flush         = 1'b1;
          pend_tgt_nx   = win_tgt;
          pend_cause_nx = win_cause;
        end
        // A trap/mret arriving together with imem_ready goes out directly.
        if (imem_ready) begin
          jmp      = 1'b1;
          jmp_tgt  = urgent ? win_tgt : pend_tgt;
          cause    = urgent ? win_cause : pend_cause;
          state_nx = ST_RUN;
        end
      end

      ST_INVAL: begin
        cause      = pend_cause;
        inv_cnt_nx = inv_cnt + CNT_W'(1);
        if (urgent) begin
          // Abandon the invalidate; a late done pulse is ignored in RUN/HOLD.
          flush      = 1'b1;
          inv_cnt_nx = '0;
          if (imem_ready) begin
            jmp      = 1'b1;
            jmp_tgt  = win_tgt;
            cause    = win_cause;
            state_nx = ST_RUN;
          end else begin
            pend_tgt_nx   = win_tgt;
            pend_cause_nx = win_cause;
            state_nx      = ST_HOLD;
          end
        end else if (icache_inv_done || (inv_cnt == CNT_LAST)) begin
          flush      = 1'b1;
          inv_cnt_nx = '0;
          if (imem_ready) begin
            jmp      = 1'b1;
            jmp_tgt  = pend_tgt;
            cause    = pend_cause;
            state_nx = ST_RUN;
          end else begin
            state_nx = ST_HOLD;
          end
        end
      end

      default: state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      pend_tgt   <= '0;
      pend_cause <= CAUSE_NONE;
      inv_cnt    <= '0;
    end else begin
      state      <= state_nx;
      pend_tgt   <= pend_tgt_nx;
      pend_cause <= pend_cause_nx;
      inv_cnt    <= inv_cnt_nx;
    end
  end

  // Every output is forced low during the reset cycle.
  assign pc_j_signal    = !rst && jmp;
  assign pc_jump        = rst ? 32'd0 : jmp_tgt;
  assign pc_stall       = !rst && !jmp &&
                          (load_use_hazard || !imem_ready || (state != ST_RUN) || fence_start);
  assign flush_if_id    = !rst && flush;
  assign flush_id_ex    = !rst && flush;
  assign icache_inv_req = !rst && inv_req;
  assign redirect_cause = rst ? CAUSE_NONE : cause;
  assign busy           = !rst && (state != ST_RUN);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus random traffic, all
// cycles scored against a queue of expected outputs from a reference model.
module tb_pc_redirect_ctrl;

  localparam int INV_T = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req, mret_req, br_taken, fencei_req;
  logic [31:0] trap_vector, mepc, br_target, fencei_pc;
  logic        icache_inv_done, load_use_hazard, imem_ready;
  logic        pc_j_signal, pc_stall, flush_if_id, flush_id_ex, icache_inv_req, busy;
  logic [31:0] pc_jump;
  logic [2:0]  redirect_cause;

  typedef struct packed {
    logic        j;
    logic [31:0] jump;
    logic        stall;
    logic        fl_ifid;
    logic        fl_idex;
    logic        inv;
    logic [2:0]  cause;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: mode 0 = running, 1 = redirect parked, 2 = invalidating
  int          m_mode = 0;
  logic [31:0] m_tgt = '0;
  int          m_cause = 0;
  int          m_cnt = 0;

  pc_redirect_ctrl #(.INV_TIMEOUT(INV_T)) dut (
    .clk             (clk),
    .rst             (rst),
    .trap_req        (trap_req),
    .trap_vector     (trap_vector),
    .mret_req        (mret_req),
    .mepc            (mepc),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fencei_req      (fencei_req),
    .fencei_pc       (fencei_pc),
    .icache_inv_done (icache_inv_done),
    .load_use_hazard (load_use_hazard),
    .imem_ready      (imem_ready),
    .pc_j_signal     (pc_j_signal),
    .pc_jump         (pc_jump),
    .pc_stall        (pc_stall),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .icache_inv_req  (icache_inv_req),
    .redirect_cause  (redirect_cause),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Compute this cycle's expected outputs from the current inputs and
  // advance the model to the state it will hold after the next edge.
  task automatic model_push();
    exp_t        e;
    int          wc, icause, mode0;
    logic [31:0] wt, itgt;
    bit          urgent, issue, fstart;
    e = '0;
    if (rst) begin
      m_mode = 0; m_tgt = '0; m_cause = 0; m_cnt = 0;
    end else begin
      wc = 0; wt = '0; itgt = '0; icause = 0;
      if (trap_req)        begin wc = 1; wt = trap_vector; end
      else if (mret_req)   begin wc = 2; wt = mepc;        end
      else if (br_taken)   begin wc = 3; wt = br_target;   end
      else if (fencei_req) begin wc = 4; wt = fencei_pc;   end
      wt[1:0] = 2'b00;
      urgent = (wc == 1) || (wc == 2);
      mode0  = m_mode;
      issue  = 1'b0;
      fstart = 1'b0;
      if (mode0 != 0) e.cause = 3'(m_cause);
      case (mode0)
        0: begin
          if (wc >= 1 && wc <= 3) begin
            e.fl_ifid = 1'b1; e.fl_idex = 1'b1;
            if (imem_ready) begin issue = 1'b1; itgt = wt; icause = wc; end
            else begin m_tgt = wt; m_cause = wc; m_mode = 1; end
          end else if (wc == 4) begin
            e.inv = 1'b1; e.fl_ifid = 1'b1; e.fl_idex = 1'b1; fstart = 1'b1;
            m_tgt = wt; m_cause = 4; m_cnt = 0; m_mode = 2;
          end
        end
        1: begin
          if (urgent) begin
            e.fl_ifid = 1'b1; e.fl_idex = 1'b1;
            m_tgt = wt; m_cause = wc;
          end
          if (imem_ready) begin issue = 1'b1; itgt = m_tgt; icause = m_cause; m_mode = 0; end
        end
        default: begin
          if (urgent) begin
            e.fl_ifid = 1'b1; e.fl_idex = 1'b1; m_cnt = 0;
            if (imem_ready) begin issue = 1'b1; itgt = wt; icause = wc; m_mode = 0; end
            else begin m_tgt = wt; m_cause = wc; m_mode = 1; end
          end else if (icache_inv_done || m_cnt == INV_T - 1) begin
            e.fl_ifid = 1'b1; e.fl_idex = 1'b1; m_cnt = 0;
            if (imem_ready) begin issue = 1'b1; itgt = m_tgt; icause = m_cause; m_mode = 0; end
            else m_mode = 1;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      endcase
      if (issue) begin
        e.j = 1'b1; e.jump = itgt; e.cause = 3'(icause);
      end
      e.stall = issue ? 1'b0 : (load_use_hazard || !imem_ready || mode0 != 0 || fstart);
      e.busy  = (mode0 != 0);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: scores every presented cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.j = pc_j_signal;       a.jump = pc_jump;         a.stall = pc_stall;
      a.fl_ifid = flush_if_id; a.fl_idex = flush_id_ex;  a.inv = icache_inv_req;
      a.cause = redirect_cause; a.busy = busy;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t got j=%0b jump=%h stall=%0b fl=%0b%0b inv=%0b cause=%0d busy=%0b | exp j=%0b jump=%h stall=%0b fl=%0b%0b inv=%0b cause=%0d busy=%0b",
                 $time, a.j, a.jump, a.stall, a.fl_ifid, a.fl_idex, a.inv, a.cause, a.busy,
                 e.j, e.jump, e.stall, e.fl_ifid, e.fl_idex, e.inv, e.cause, e.busy);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    trap_req = 1'b0; mret_req = 1'b0; br_taken = 1'b0; fencei_req = 1'b0;
    trap_vector = $urandom; mepc = $urandom; br_target = $urandom; fencei_pc = $urandom;
    icache_inv_done = 1'b0; load_use_hazard = 1'b0; imem_ready = 1'b1;
  endtask

  // cyc: inputs are set, expectation queued, outputs settled for directed checks.
  task automatic cyc();
    model_push();
    #2;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset with requests active: outputs must all be 0
    idle(); rst = 1'b1; trap_req = 1'b1; br_taken = 1'b1; imem_ready = 1'b0; load_use_hazard = 1'b1;
    cyc();
    chk("rst_j", 32'(pc_j_signal), 32'd0);
    chk("rst_stall", 32'(pc_stall), 32'd0);
    chk("rst_flush", 32'(flush_if_id), 32'd0);
    adv();
    idle(); cyc(); adv();

    // Taken branch, imem ready
    idle(); br_taken = 1'b1; br_target = 32'h100;
    cyc();
    chk("br_j", 32'(pc_j_signal), 32'd1);
    chk("br_jump", pc_jump, 32'h100);
    chk("br_flush_ifid", 32'(flush_if_id), 32'd1);
    chk("br_flush_idex", 32'(flush_id_ex), 32'd1);
    chk("br_cause", 32'(redirect_cause), 32'd3);
    chk("br_stall", 32'(pc_stall), 32'd0);
    adv();
    idle(); cyc(); chk("br_busy_next", 32'(busy), 32'd0); adv();

    // Coincident trap/mret/branch: trap wins
    idle(); trap_req = 1'b1; trap_vector = 32'h80; mret_req = 1'b1; mepc = 32'h500;
    br_taken = 1'b1; br_target = 32'h300;
    cyc();
    chk("prio_jump", pc_jump, 32'h80);
    chk("prio_cause", 32'(redirect_cause), 32'd1);
    adv();

    // Branch while imem busy for 3 cycles, misaligned target
    idle(); br_taken = 1'b1; br_target = 32'h203; imem_ready = 1'b0;
    cyc(); chk("hold_stall0", 32'(pc_stall), 32'd1); chk("hold_j0", 32'(pc_j_signal), 32'd0); adv();
    for (int i = 0; i < 2; i++) begin
      idle(); imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h900;
      cyc();
      chk("hold_stall", 32'(pc_stall), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_cause", 32'(redirect_cause), 32'd3);
      adv();
    end
    idle(); cyc();
    chk("hold_rel_j", 32'(pc_j_signal), 32'd1);
    chk("hold_rel_jump", pc_jump, 32'h200);
    adv();

    // Trap overrides a parked branch
    idle(); br_taken = 1'b1; br_target = 32'h203; imem_ready = 1'b0; cyc(); adv();
    idle(); imem_ready = 1'b0; trap_req = 1'b1; trap_vector = 32'h40;
    cyc(); chk("hold_trap_flush", 32'(flush_if_id), 32'd1); adv();
    idle(); cyc();
    chk("hold_trap_jump", pc_jump, 32'h40);
    chk("hold_trap_cause", 32'(redirect_cause), 32'd1);
    adv();

    // fence.i with done on the 5th INVAL cycle
    idle(); fencei_req = 1'b1; fencei_pc = 32'h24;
    cyc();
    chk("fi_inv", 32'(icache_inv_req), 32'd1);
    chk("fi_stall", 32'(pc_stall), 32'd1);
    adv();
    for (int i = 0; i < 4; i++) begin
      idle(); cyc();
      chk("fi_inv_once", 32'(icache_inv_req), 32'd0);
      chk("fi_wait_stall", 32'(pc_stall), 32'd1);
      adv();
    end
    idle(); icache_inv_done = 1'b1; cyc();
    chk("fi_done_j", 32'(pc_j_signal), 32'd1);
    chk("fi_done_jump", pc_jump, 32'h24);
    chk("fi_done_cause", 32'(redirect_cause), 32'd4);
    adv();

    // fence.i timeout
    idle(); fencei_req = 1'b1; fencei_pc = 32'h1234; cyc(); adv();
    for (int i = 0; i < INV_T - 1; i++) begin
      idle(); cyc(); chk("to_wait_j", 32'(pc_j_signal), 32'd0); adv();
    end
    idle(); cyc();
    chk("to_j", 32'(pc_j_signal), 32'd1);
    chk("to_jump", pc_jump, 32'h1234);
    adv();

    // Reset while in INVAL, then a late done pulse
    idle(); fencei_req = 1'b1; fencei_pc = 32'h48; cyc(); adv();
    idle(); cyc(); adv();
    idle(); rst = 1'b1; icache_inv_done = 1'b1; br_taken = 1'b1;
    cyc();
    chk("rstinv_j", 32'(pc_j_signal), 32'd0);
    chk("rstinv_stall", 32'(pc_stall), 32'd0);
    chk("rstinv_busy", 32'(busy), 32'd0);
    chk("rstinv_cause", 32'(redirect_cause), 32'd0);
    adv();
    idle(); icache_inv_done = 1'b1; cyc();
    chk("late_done_j", 32'(pc_j_signal), 32'd0);
    chk("late_done_busy", 32'(busy), 32'd0);
    adv();

    // Load-use hazard alone, then with a branch
    idle(); load_use_hazard = 1'b1; cyc();
    chk("haz_stall", 32'(pc_stall), 32'd1);
    chk("haz_j", 32'(pc_j_signal), 32'd0);
    adv();
    idle(); load_use_hazard = 1'b1; br_taken = 1'b1; br_target = 32'h44; cyc();
    chk("haz_br_j", 32'(pc_j_signal), 32'd1);
    chk("haz_br_stall", 32'(pc_stall), 32'd0);
    adv();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst             = ($urandom_range(0, 99) < 2);
      trap_req        = ($urandom_range(0, 99) < 4);
      mret_req        = ($urandom_range(0, 99) < 4);
      br_taken        = ($urandom_range(0, 99) < 20);
      fencei_req      = ($urandom_range(0, 99) < 6);
      icache_inv_done = ($urandom_range(0, 99) < 12);
      load_use_hazard = ($urandom_range(0, 99) < 20);
      imem_ready      = ($urandom_range(0, 99) < 65);
      trap_vector = $urandom; mepc = $urandom; br_target = $urandom; fencei_pc = $urandom;
      cyc();
      adv();
    end

    idle(); cyc(); adv();
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got=%0d left exp=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
